// File: rtl/arb_tcp_bridge.sv
// Buffers 32-bit arbiter words and serializes them little-endian onto the
// SiTCP 8-bit transmit stream; a closed connection flushes everything.
module arb_tcp_bridge #(
  parameter int unsigned DEPTH         = 1024,
  parameter int unsigned NEAR_FULL_THR = 768
) (
  input  logic                     BUS_CLK,
  input  logic                     BUS_RST_N,
  input  logic                     ARB_WRITE,
  input  logic [31:0]              ARB_DATA,
  output logic                     ARB_READY,
  output logic                     FIFO_FULL,
  output logic                     FIFO_NEAR_FULL,
  input  logic                     TCP_OPEN,
  input  logic                     TCP_TX_FULL,
  output logic                     TCP_TX_WR,
  output logic [7:0]               TCP_TX_DATA,
  output logic [$clog2(DEPTH):0]   FIFO_SIZE,
  output logic [7:0]               LOST_COUNT
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state_q, state_d;
  logic [31:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [31:0]     shift_q;
  logic [1:0]      idx_q;
  logic [7:0]      lost_q;

  logic push, pop, overflow, send_byte, not_empty;

  // Flags decode from the registered occupancy only, so a pop in the
  // same cycle can never open a slot for a word on a full buffer.
  assign FIFO_FULL      = (count_q == CW'(DEPTH));
  assign FIFO_NEAR_FULL = (count_q >= CW'(NEAR_FULL_THR));
  assign ARB_READY      = ~FIFO_FULL;
  assign FIFO_SIZE      = count_q;
  assign LOST_COUNT     = lost_q;
  assign not_empty      = (count_q != '0);

  assign push      = ARB_WRITE & ~FIFO_FULL & TCP_OPEN;
  assign overflow  = ARB_WRITE &  FIFO_FULL & TCP_OPEN;

  assign TCP_TX_WR   = (state_q == SEND) & ~TCP_TX_FULL & TCP_OPEN;
  assign TCP_TX_DATA = shift_q[8*idx_q +: 8];

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    send_byte = 1'b0;
    if (!TCP_OPEN) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (not_empty) begin
            pop     = 1'b1;
            state_d = SEND;
          end
        end
        SEND: begin
          if (!TCP_TX_FULL) begin
            send_byte = 1'b1;
            if (idx_q == 2'd3) begin
              // Chain straight into the next word to avoid a bubble.
              if (not_empty) pop = 1'b1;
              else           state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_ff @(posedge BUS_CLK) begin
    if (push) mem[wr_ptr_q] <= ARB_DATA;
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      shift_q  <= '0;
      idx_q    <= '0;
    end else if (!TCP_OPEN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      idx_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
      if (pop) begin
        shift_q <= mem[rd_ptr_q];
        idx_q   <= '0;
      end else if (send_byte) begin
        idx_q <= idx_q + 2'd1;
      end
    end
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N)                      lost_q <= '0;
    else if (overflow && lost_q != '1)   lost_q <= lost_q + 8'd1;
  end

endmodule

// File: tb/tb_arb_tcp_bridge.sv
// Directed scoreboard bench for arb_tcp_bridge: expected bytes are queued
// when words are pushed and compared whenever TCP_TX_WR is seen.
module tb_arb_tcp_bridge;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned NFT   = 768;

  logic        BUS_CLK = 1'b0;
  logic        BUS_RST_N;
  logic        ARB_WRITE;
  logic [31:0] ARB_DATA;
  logic        ARB_READY, FIFO_FULL, FIFO_NEAR_FULL;
  logic        TCP_OPEN, TCP_TX_FULL, TCP_TX_WR;
  logic [7:0]  TCP_TX_DATA, LOST_COUNT;
  logic [10:0] FIFO_SIZE;

  arb_tcp_bridge #(.DEPTH(DEPTH), .NEAR_FULL_THR(NFT)) dut (
    .BUS_CLK(BUS_CLK), .BUS_RST_N(BUS_RST_N),
    .ARB_WRITE(ARB_WRITE), .ARB_DATA(ARB_DATA), .ARB_READY(ARB_READY),
    .FIFO_FULL(FIFO_FULL), .FIFO_NEAR_FULL(FIFO_NEAR_FULL),
    .TCP_OPEN(TCP_OPEN), .TCP_TX_FULL(TCP_TX_FULL),
    .TCP_TX_WR(TCP_TX_WR), .TCP_TX_DATA(TCP_TX_DATA),
    .FIFO_SIZE(FIFO_SIZE), .LOST_COUNT(LOST_COUNT)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;
  logic [7:0]  sb[$];
  int          cyc_no = 0, wr_cnt = 0, first_wr = -1, last_wr = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Sample just before the consuming edge, with this cycle's inputs stable.
  task automatic to_neg();
    @(negedge BUS_CLK);
    if (TCP_TX_WR === 1'b1) begin
      wr_cnt++;
      if (first_wr < 0) first_wr = cyc_no;
      last_wr = cyc_no;
      if (sb.size() == 0) check("tx_unexpected", 32'd1, 32'd0);
      else                check("tx_byte", 32'(TCP_TX_DATA), 32'(sb.pop_front()));
    end
  endtask

  task automatic to_pos();
    @(posedge BUS_CLK);
    #1;
    cyc_no++;
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      to_neg();
      to_pos();
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    ARB_WRITE = 1'b1;
    ARB_DATA  = w;
    for (int b = 0; b < 4; b++) sb.push_back(w[8*b +: 8]);
    cyc(1);
    ARB_WRITE = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_wr"},    32'(TCP_TX_WR), 32'd0);
    check({tag, "_data"},  32'(TCP_TX_DATA), 32'd0);
    check({tag, "_size"},  32'(FIFO_SIZE), 32'd0);
    check({tag, "_full"},  32'(FIFO_FULL), 32'd0);
    check({tag, "_nfull"}, 32'(FIFO_NEAR_FULL), 32'd0);
    check({tag, "_ready"}, 32'(ARB_READY), 32'd1);
    check({tag, "_lost"},  32'(LOST_COUNT), 32'd0);
  endtask

  initial begin : stim
    int occ, lost, wr0;
    bit popped, acc, pp;

    BUS_RST_N = 1'b1; ARB_WRITE = 1'b0; ARB_DATA = '0;
    TCP_OPEN = 1'b1; TCP_TX_FULL = 1'b0;
    #1 BUS_RST_N = 1'b0;
    #2 check_reset_values("rst");
    to_pos(); to_pos();
    BUS_RST_N = 1'b1;
    cyc(1);

    // Single word: latency and little-endian order.
    push_word(32'h44332211);
    check("lat_size1", 32'(FIFO_SIZE), 32'd1);
    wr0 = wr_cnt;
    cyc(1);
    check("lat_no_wr_yet", 32'(wr_cnt - wr0), 32'd0);
    cyc(4);
    check("lat_four_bytes", 32'(wr_cnt - wr0), 32'd4);
    cyc(2);
    check("lat_no_extra", 32'(wr_cnt - wr0), 32'd4);
    check("lat_size0", 32'(FIFO_SIZE), 32'd0);
    check("lat_drain", 32'(sb.size()), 32'd0);

    // Three back-to-back words: 12 contiguous strobes.
    first_wr = -1; wr0 = wr_cnt;
    push_word(32'h0D0C0B0A);
    push_word(32'h1D1C1B1A);
    push_word(32'h2D2C2B2A);
    cyc(16);
    check("b2b_count", 32'(wr_cnt - wr0), 32'd12);
    check("b2b_span", 32'(last_wr - first_wr + 1), 32'd12);
    check("b2b_drain", 32'(sb.size()), 32'd0);

    // Stall after the first byte.
    push_word(32'hAABBCCDD);
    cyc(2);
    TCP_TX_FULL = 1'b1;
    for (int i = 0; i < 5; i++) begin
      to_neg();
      check("stall_wr", 32'(TCP_TX_WR), 32'd0);
      check("stall_data", 32'(TCP_TX_DATA), 32'hCC);
      to_pos();
    end
    TCP_TX_FULL = 1'b0;
    cyc(4);
    check("stall_drain", 32'(sb.size()), 32'd0);

    // Overflow with the transmitter blocked; model occupancy independently.
    TCP_TX_FULL = 1'b1;
    occ = 0; lost = 0; popped = 1'b0;
    for (int i = 0; i < int'(DEPTH) + 300; i++) begin
      ARB_WRITE = 1'b1;
      ARB_DATA  = 32'(i);
      acc = (occ < int'(DEPTH));
      pp  = !popped && occ != 0;
      if (!acc && lost < 255) lost++;
      popped = popped | pp;
      occ = occ + int'(acc) - int'(pp);
      cyc(1);
      check("ovf_size",  32'(FIFO_SIZE), 32'(occ));
      check("ovf_nfull", 32'(FIFO_NEAR_FULL), 32'(occ >= int'(NFT)));
      check("ovf_full",  32'(FIFO_FULL), 32'(occ == int'(DEPTH)));
      check("ovf_ready", 32'(ARB_READY), 32'(occ != int'(DEPTH)));
      check("ovf_lost",  32'(LOST_COUNT), 32'(lost));
    end
    ARB_WRITE = 1'b0;
    check("ovf_end_size", 32'(FIFO_SIZE), 32'd1024);
    check("ovf_end_ready", 32'(ARB_READY), 32'd0);
    check("ovf_end_lost", 32'(LOST_COUNT), 32'd255);

    // Close the connection: flush, and drops while closed are not counted.
    TCP_TX_FULL = 1'b0;
    TCP_OPEN = 1'b0;
    sb.delete();
    to_neg();
    check("close_wr", 32'(TCP_TX_WR), 32'd0);
    to_pos();
    check("close_size", 32'(FIFO_SIZE), 32'd0);
    check("close_full", 32'(FIFO_FULL), 32'd0);
    check("close_ready", 32'(ARB_READY), 32'd1);
    ARB_WRITE = 1'b1; ARB_DATA = 32'h12345678;
    cyc(2);
    ARB_WRITE = 1'b0;
    check("closed_size", 32'(FIFO_SIZE), 32'd0);
    check("closed_lost", 32'(LOST_COUNT), 32'd255);
    TCP_OPEN = 1'b1;

    // Fresh reset, then close mid-word with 10 words buffered.
    #2 BUS_RST_N = 1'b0;
    #2 BUS_RST_N = 1'b1;
    sb.delete();
    to_pos();
    TCP_TX_FULL = 1'b1;
    for (int i = 0; i < 11; i++) push_word(32'hC0DE0000 + 32'(i));
    check("mid_size10", 32'(FIFO_SIZE), 32'd10);
    TCP_TX_FULL = 1'b0;
    cyc(2);
    TCP_OPEN = 1'b0;
    sb.delete();
    to_neg();
    check("mid_close_wr", 32'(TCP_TX_WR), 32'd0);
    to_pos();
    check("mid_close_size", 32'(FIFO_SIZE), 32'd0);
    check("mid_close_ready", 32'(ARB_READY), 32'd1);
    check("mid_close_lost", 32'(LOST_COUNT), 32'd0);
    cyc(1);
    TCP_OPEN = 1'b1;
    push_word(32'h5A5AA5A5);
    cyc(7);
    check("reopen_drain", 32'(sb.size()), 32'd0);
    check("reopen_size", 32'(FIFO_SIZE), 32'd0);

    // Asynchronous reset in the middle of a word.
    push_word(32'h04030201);
    cyc(3);
    #2 BUS_RST_N = 1'b0;
    #1 check_reset_values("arst");
    sb.delete();
    wr0 = wr_cnt;
    cyc(2);
    BUS_RST_N = 1'b1;
    cyc(8);
    check("arst_no_wr", 32'(wr_cnt - wr0), 32'd0);
    push_word(32'hCAFEF00D);
    cyc(7);
    check("arst_new_drain", 32'(sb.size()), 32'd0);
    check("arst_new_count", 32'(wr_cnt - wr0), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
